truth_table_checker: RTL

//  Sequential exhaustive-equivalence stage for two gate-level variants of one
//  N_IN-input Boolean function (e.g. NAND-only form vs. expression form).

---
 rtl/truth_table_checker_if.sv | 26 ++
 rtl/truth_table_checker.sv | 100 ++++++++++
 2 files changed

// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and the two variants under comparison.
// The master side drives the run request and the variant outputs.
interface truth_table_checker_if #(
   parameter int N_IN = 2
);
   logic              start;
   logic              a_in;
   logic              b_in;
   logic [N_IN-1:0]   x_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     err_count;
   logic [N_IN-1:0]   first_err_vec;
   logic              first_err_valid;

   modport master (
      output start, a_in, b_in,
      input  x_out, busy, done, pass, err_count, first_err_vec, first_err_valid
   );

   modport slave (
      input  start, a_in, b_in,
      output x_out, busy, done, pass, err_count, first_err_vec, first_err_valid
   );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps every N_IN-bit vector into two Boolean variants and compares their outputs,
// counting mismatches and capturing the first failing vector.
//
// state  | meaning
// IDLE   | waiting for start; previous results held
// DRIVE  | x_out held for SETTLE cycles so both variants settle
// SAMPLE | compare a_in/b_in, advance to next vector or finish
// DONE   | one-cycle done pulse with final pass/err results
module truth_table_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input logic                 clk,
   input logic                 reset,
   truth_table_checker_if.slave bus
);
   localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [N_IN-1:0] X_LAST      = '1;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t            state;
   logic [SW-1:0]     settle_cnt;
   logic [N_IN-1:0]   x_r;
   logic              busy_r;
   logic              done_r;
   logic              pass_r;
   logic [N_IN:0]     err_r;
   logic [N_IN-1:0]   fev_r;
   logic              fv_r;
   logic              mismatch;

   assign mismatch = bus.a_in ^ bus.b_in;

   assign bus.x_out           = x_r;
   assign bus.busy            = busy_r;
   assign bus.done            = done_r;
   assign bus.pass            = pass_r;
   assign bus.err_count       = err_r;
   assign bus.first_err_vec   = fev_r;
   assign bus.first_err_valid = fv_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         settle_cnt <= '0;
         x_r        <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         err_r      <= '0;
         fev_r      <= '0;
         fv_r       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= DRIVE;
                  busy_r     <= 1'b1;
                  x_r        <= '0;
                  settle_cnt <= '0;
                  err_r      <= '0;
                  fv_r       <= 1'b0;
                  pass_r     <= 1'b0;
               end
            end
            DRIVE: begin
               // counter parks at its last value; it is reloaded per vector
               if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
               else settle_cnt <= settle_cnt + 1'b1;
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_r <= err_r + 1'b1;
                  if (!fv_r) begin
                     fev_r <= x_r;
                     fv_r  <= 1'b1;
                  end
               end
               if (x_r == X_LAST) begin
                  state  <= DONE;
                  done_r <= 1'b1;
                  pass_r <= (err_r == '0) && !mismatch;
               end else begin
                  x_r        <= x_r + 1'b1;
                  settle_cnt <= '0;
                  state      <= DRIVE;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
